paddle_motion: RTL and testbench

PADDLE_MOTION -- requirements
Module: paddle_motion

---
 rtl/paddle_motion.sv | 120 ++++++++++++
 tb/tb_paddle_motion.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/paddle_motion.sv
// Paddle position controller: manual or ball-tracking commands drive a
// ramp-then-cruise stepper that moves the paddle one pixel per interval.
module paddle_motion #(
    parameter int unsigned V_VIDEO     = 480,
    parameter int unsigned PDL_HEIGHT  = 96,
    parameter int unsigned START_X     = 24,
    parameter int unsigned SLOW_PSC    = 41958,
    parameter int unsigned FAST_PSC    = 20979,
    parameter int unsigned ACCEL_STEPS = 8,
    parameter int unsigned AI_DEADBAND = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reset_game,
    input  logic       mode_ai,
    input  logic       move_up,
    input  logic       move_down,
    input  logic [9:0] ball_y,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       step,
    output logic       at_top,
    output logic       at_bottom
);

    localparam int unsigned VW = $clog2(SLOW_PSC);
    localparam int unsigned SW = (ACCEL_STEPS < 1) ? 1 : $clog2(ACCEL_STEPS + 1);
    localparam logic [9:0]  Y_HOME = 10'(V_VIDEO / 2 - PDL_HEIGHT / 2);
    localparam logic [9:0]  Y_MAX  = 10'(V_VIDEO - PDL_HEIGHT);

    typedef enum logic [1:0] {CMD_NONE, CMD_UP, CMD_DOWN} cmd_t;
    typedef enum logic [1:0] {IDLE, RAMP, CRUISE} state_t;

    state_t          state;
    cmd_t            dir_q;
    cmd_t            cmd;
    logic [VW-1:0]   vel_count;
    logic [SW-1:0]   step_cnt;
    logic [VW-1:0]   vel_last;
    logic [10:0]     centre;
    logic [10:0]     ball_lo;
    logic [10:0]     centre_hi;
    logic            up_blocked;
    logic            down_blocked;
    logic            can_move;

    assign x_pos     = 10'(START_X);
    assign at_top    = (y_pos == '0);
    assign at_bottom = (y_pos == Y_MAX);

    always_comb begin
        centre    = {1'b0, y_pos} + 11'(PDL_HEIGHT / 2);
        ball_lo   = {1'b0, ball_y} + 11'(AI_DEADBAND);
        centre_hi = centre + 11'(AI_DEADBAND);
        cmd       = CMD_NONE;
        if (mode_ai) begin
            if (ball_lo < centre)
                cmd = CMD_UP;
            else if ({1'b0, ball_y} > centre_hi)
                cmd = CMD_DOWN;
        end else begin
            if (move_up && !move_down)
                cmd = CMD_UP;
            else if (move_down && !move_up)
                cmd = CMD_DOWN;
        end
    end

    always_comb begin
        vel_last     = (state == CRUISE) ? VW'(FAST_PSC - 1) : VW'(SLOW_PSC - 1);
        up_blocked   = (y_pos == '0);
        down_blocked = ({1'b0, y_pos} + 11'(PDL_HEIGHT)) >= 11'(V_VIDEO);
        can_move     = (dir_q == CMD_UP) ? !up_blocked : !down_blocked;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_pos     <= Y_HOME;
            step      <= 1'b0;
            state     <= IDLE;
            dir_q     <= CMD_NONE;
            vel_count <= '0;
            step_cnt  <= '0;
        end else begin
            step <= 1'b0;
            if (reset_game) begin
                y_pos     <= Y_HOME;
                state     <= IDLE;
                dir_q     <= CMD_NONE;
                vel_count <= '0;
                step_cnt  <= '0;
            end else if (cmd == CMD_NONE) begin
                state     <= IDLE;
                dir_q     <= CMD_NONE;
                vel_count <= '0;
                step_cnt  <= '0;
            end else if (cmd != dir_q) begin
                state     <= RAMP;
                dir_q     <= cmd;
                vel_count <= '0;
                step_cnt  <= '0;
            end else if (vel_count < vel_last) begin
                vel_count <= vel_count + VW'(1);
            end else begin
                // Interval expires even when the step is blocked at an edge.
                vel_count <= '0;
                if (can_move) begin
                    y_pos <= (dir_q == CMD_UP) ? y_pos - 10'd1 : y_pos + 10'd1;
                    step  <= 1'b1;
                    if (state == RAMP) begin
                        step_cnt <= step_cnt + SW'(1);
                        if (step_cnt == SW'(ACCEL_STEPS - 1))
                            state <= CRUISE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_paddle_motion.sv
// Bench for paddle_motion: countdown-based reference model checked every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_paddle_motion;

    localparam int SLOW  = 4;
    localparam int FAST  = 2;
    localparam int ACCEL = 3;
    localparam int VV    = 480;
    localparam int PH    = 96;
    localparam int SX    = 24;
    localparam int DB    = 8;
    localparam int HOME  = VV / 2 - PH / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reset_game = 1'b0;
    logic       mode_ai = 1'b0;
    logic       move_up = 1'b0;
    logic       move_down = 1'b0;
    logic [9:0] ball_y = '0;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       step;
    logic       at_top;
    logic       at_bottom;

    int checks = 0;
    int errors = 0;

    // Reference model: y position, current command, edges left until the
    // next step attempt, and steps applied since the command began.
    int m_y     = HOME;
    int m_dir   = 0;
    int m_due   = 0;
    int m_steps = 0;
    int m_step  = 0;

    paddle_motion #(
        .V_VIDEO(VV), .PDL_HEIGHT(PH), .START_X(SX), .SLOW_PSC(SLOW),
        .FAST_PSC(FAST), .ACCEL_STEPS(ACCEL), .AI_DEADBAND(DB)
    ) dut (
        .clk(clk), .rst(rst), .reset_game(reset_game), .mode_ai(mode_ai),
        .move_up(move_up), .move_down(move_down), .ball_y(ball_y),
        .x_pos(x_pos), .y_pos(y_pos), .step(step),
        .at_top(at_top), .at_bottom(at_bottom)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_cmd();
        int centre;
        int by;
        by = int'(ball_y);
        centre = m_y + PH / 2;
        if (mode_ai) begin
            if (by + DB < centre) return 1;
            if (by > centre + DB) return 2;
            return 0;
        end
        if (move_up && !move_down) return 1;
        if (move_down && !move_up) return 2;
        return 0;
    endfunction

    initial forever begin
        int c;
        @(posedge clk or posedge rst);
        m_step = 0;
        if (rst || reset_game) begin
            m_y = HOME; m_dir = 0; m_due = 0; m_steps = 0;
        end else begin
            c = model_cmd();
            if (c == 0) begin
                m_dir = 0;
            end else if (c != m_dir) begin
                m_dir = c; m_due = SLOW; m_steps = 0;
            end else begin
                m_due--;
                if (m_due == 0) begin
                    if (m_dir == 1 && m_y > 0) begin
                        m_y--; m_steps++; m_step = 1;
                    end else if (m_dir == 2 && m_y + PH < VV) begin
                        m_y++; m_steps++; m_step = 1;
                    end
                    m_due = (m_steps >= ACCEL) ? FAST : SLOW;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("y_pos", int'(y_pos), m_y);
        chk("step", int'(step), m_step);
        chk("at_top", int'(at_top), int'(m_y == 0));
        chk("at_bottom", int'(at_bottom), int'(m_y == VV - PH));
        chk("x_pos", int'(x_pos), SX);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_y", int'(y_pos), 192);
        chk("reset_step", int'(step), 0);
        chk("reset_top", int'(at_top), 0);

        // Hold down from rest: ramp steps at edges 5, 9, 13, then every 2.
        move_down = 1'b1;
        repeat (5) @(negedge clk);
        chk("ramp_e5", int'(y_pos), 193);
        chk("ramp_e5_step", int'(step), 1);
        @(negedge clk);
        chk("ramp_e6_step", int'(step), 0);
        repeat (3) @(negedge clk);
        chk("ramp_e9", int'(y_pos), 194);
        repeat (4) @(negedge clk);
        chk("ramp_e13", int'(y_pos), 195);
        repeat (2) @(negedge clk);
        chk("cruise_e15", int'(y_pos), 196);
        repeat (2) @(negedge clk);
        chk("cruise_e17", int'(y_pos), 197);

        // Reversal restarts the ramp with no step on the switch edge.
        move_down = 1'b0; move_up = 1'b1;
        @(negedge clk);
        chk("rev_switch_y", int'(y_pos), 197);
        chk("rev_switch_step", int'(step), 0);
        repeat (3) @(negedge clk);
        chk("rev_e4", int'(y_pos), 197);
        @(negedge clk);
        chk("rev_e5", int'(y_pos), 196);

        // Both buttons: no motion.
        move_down = 1'b1;
        repeat (10) @(negedge clk);
        chk("both_y", int'(y_pos), 196);
        chk("both_step", int'(step), 0);

        // Run into the top and press against it.
        move_down = 1'b0;
        repeat (600) @(negedge clk);
        chk("top_y", int'(y_pos), 0);
        chk("top_flag", int'(at_top), 1);
        repeat (20) begin
            @(negedge clk);
            chk("top_no_step", int'(step), 0);
        end

        // AI tracking towards ball_y=400 settles at centre 392.
        move_up = 1'b0; reset_game = 1'b1;
        @(negedge clk);
        reset_game = 1'b0;
        chk("rg_y", int'(y_pos), 192);
        mode_ai = 1'b1; ball_y = 10'd400;
        repeat (400) @(negedge clk);
        chk("ai_hold_y", int'(y_pos), 344);
        ball_y = 10'd1000;
        repeat (200) @(negedge clk);
        chk("ai_bottom_y", int'(y_pos), 384);
        chk("ai_bottom_flag", int'(at_bottom), 1);

        // reset_game during cruise, then ramp from scratch.
        mode_ai = 1'b0; move_up = 1'b1;
        repeat (30) @(negedge clk);
        reset_game = 1'b1;
        @(negedge clk);
        reset_game = 1'b0;
        chk("rg_cruise_y", int'(y_pos), 192);
        repeat (4) @(negedge clk);
        chk("rg_e4", int'(y_pos), 192);
        @(negedge clk);
        chk("rg_e5", int'(y_pos), 191);

        // Asynchronous reset mid-interval.
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_now_y", int'(y_pos), 192);
        chk("rst_now_step", int'(step), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_e4", int'(y_pos), 192);
        @(negedge clk);
        chk("rst_e5", int'(y_pos), 191);

        // Randomised phase against the model.
        move_up = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset_game = 1'b0;
            if ($urandom_range(0, 15) == 0) move_up = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) move_down = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 199) == 0) mode_ai = ~mode_ai;
            if ($urandom_range(0, 49) == 0) ball_y = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 299) == 0) reset_game = 1'b1;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end
        reset_game = 1'b0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
